wb_block_master: RTL and testbench

Wishbone bus initiator that executes block read and block write transfers of consecutive words on behalf of a local controller (DMA engine, JTAG loader, NoC endpoint). It is the master-side counterpart of the single-port Wishbone RAM slave and connects directly to its `sa_*` port or to a bus interconnect. Commands arrive on a valid/ready command port. Write data is pulled from a valid/ready stream, and read data is pushed to a valid/ready stream with one-entry buffering.

---
 rtl/wb_block_master_pkg.sv | 20 ++
 rtl/wb_block_master_if.sv | 36 +++
 rtl/wb_block_master_rd_skid.sv | 42 ++++
 rtl/wb_block_master.sv | 132 +++++++++++++
 tb/tb_wb_block_master.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_block_master_pkg.sv
// Shared types and constants for the Wishbone block master: FSM states,
// Wishbone cycle-type / burst-type codes and default widths.
package wb_master_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        GAP,
        DONE
    } state_t;

    localparam int CTIw = 3;
    localparam int BTEw = 2;

    localparam logic [CTIw-1:0] CTI_CLASSIC = 3'b000;
    localparam logic [CTIw-1:0] CTI_INC     = 3'b010;
    localparam logic [CTIw-1:0] CTI_END     = 3'b111;
    localparam logic [BTEw-1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/wb_block_master_if.sv
// Wishbone master/slave bus bundle; the master modport is the block
// master's view, the slave modport the view of a RAM or interconnect port.
interface wb_block_master_if
    import wb_master_pkg::*;
#(
    parameter int Dw = 32,
    parameter int Aw = 10
);
    localparam int SELw = Dw / 8;

    logic [Dw-1:0]   m_dat_o;
    logic [SELw-1:0] m_sel_o;
    logic [Aw-1:0]   m_addr_o;
    logic [CTIw-1:0] m_cti_o;
    logic [BTEw-1:0] m_bte_o;
    logic            m_stb_o;
    logic            m_cyc_o;
    logic            m_we_o;
    logic [Dw-1:0]   m_dat_i;
    logic            m_ack_i;
    logic            m_err_i;
    logic            m_rty_i;

    modport master (
        output m_dat_o, m_sel_o, m_addr_o, m_cti_o, m_bte_o,
        output m_stb_o, m_cyc_o, m_we_o,
        input  m_dat_i, m_ack_i, m_err_i, m_rty_i
    );

    modport slave (
        input  m_dat_o, m_sel_o, m_addr_o, m_cti_o, m_bte_o,
        input  m_stb_o, m_cyc_o, m_we_o,
        output m_dat_i, m_ack_i, m_err_i, m_rty_i
    );

endinterface

// File: rtl/wb_block_master_rd_skid.sv
// wb_rd_skid: one-entry valid/ready data register buffering read beats
// between the Wishbone bus and the local read stream.
module wb_rd_skid #(
    parameter int Dw = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [Dw-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [Dw-1:0] out_data,
    input  logic          out_ready
);

    logic          full;
    logic [Dw-1:0] data_q;

    // Accept a new word when empty, or when the held word leaves this cycle.
    assign in_ready  = ~full | out_ready;
    assign out_valid = full;
    assign out_data  = data_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full <= 1'b0;
        end else if (in_valid && in_ready) begin
            full <= 1'b1;
        end else if (out_ready) begin
            full <= 1'b0;
        end
    end

    // NOTE: the payload register is deliberately left without reset; 'full'
    // qualifies it, so resetting it would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            data_q <= in_data;
        end
    end

endmodule

// File: rtl/wb_block_master.sv
// Wishbone initiator running block read/write commands of consecutive words.
// Define WB_BLOCK_MASTER_BURST_EN for incrementing bursts; default is classic.
module wb_block_master
    import wb_master_pkg::*;
#(
    parameter int Dw   = 32,
    parameter int Aw   = 10,
    parameter int LENw = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [Aw-1:0]    cmd_addr,
    input  logic [LENw-1:0]  cmd_len,
    input  logic [Dw-1:0]    wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [Dw-1:0]    rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    wb_block_master_if.master wb
);

`ifdef WB_BLOCK_MASTER_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    state_t          state, state_nxt;
    logic            armed;
    logic            we_q;
    logic            err_q;
    logic [Aw-1:0]   addr_q;
    logic [LENw-1:0] remaining;
    logic            skid_ready;
    logic            accept;
    logic            last_beat;
    logic            beat_ack, beat_rty, beat_err;

    // 'armed' keeps cmd_ready low until the first edge after reset release.
    assign cmd_ready = armed & (state == IDLE);
    assign accept    = cmd_valid & cmd_ready;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign err       = err_q;
    assign last_beat = (remaining == LENw'(1));

    // Slave response priority: err > rty > ack.
    assign beat_err = wb.m_stb_o & wb.m_err_i;
    assign beat_rty = wb.m_stb_o & wb.m_rty_i & ~wb.m_err_i;
    assign beat_ack = wb.m_stb_o & wb.m_ack_i & ~wb.m_err_i & ~wb.m_rty_i;

    assign wb.m_cyc_o  = (state == XFER) | (state == GAP);
    assign wb.m_stb_o  = (state == XFER) & (we_q ? wr_valid : skid_ready);
    assign wb.m_we_o   = we_q & wb.m_cyc_o;
    assign wb.m_addr_o = addr_q;
    assign wb.m_dat_o  = (wb.m_stb_o & we_q) ? wr_data : '0;
    assign wb.m_sel_o  = '1;
    assign wb.m_bte_o  = BTE_LINEAR;
    assign wb.m_cti_o  = (BURST && wb.m_cyc_o) ? (last_beat ? CTI_END : CTI_INC)
                                               : CTI_CLASSIC;

    assign wr_ready = beat_ack & we_q;

    wb_rd_skid #(.Dw(Dw)) u_rd_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (beat_ack & ~we_q),
        .in_data   (wb.m_dat_i),
        .in_ready  (skid_ready),
        .out_valid (rd_valid),
        .out_data  (rd_data),
        .out_ready (rd_ready)
    );

    always_comb begin
        // NOTE: the default comes first so every path assigns state_nxt and
        // no latch is inferred.
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (cmd_len == '0) ? DONE : XFER;
                end
            end
            XFER: begin
                if (beat_err || (beat_ack && last_beat)) begin
                    state_nxt = DONE;
                end else if (beat_rty || (beat_ack && !BURST)) begin
                    state_nxt = GAP;
                end
            end
            GAP:     state_nxt = XFER;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            armed     <= 1'b0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            remaining <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples
            // the pre-edge values, independent of statement order.
            state <= state_nxt;
            armed <= 1'b1;
            if (accept) begin
                we_q      <= cmd_we;
                addr_q    <= cmd_addr;
                remaining <= cmd_len;
                err_q     <= 1'b0;
            end else if (beat_err) begin
                err_q <= 1'b1;
            end else if (beat_ack) begin
                addr_q    <= addr_q + Aw'(1);
                remaining <= remaining - LENw'(1);
            end
        end
    end

endmodule

// File: tb/tb_wb_block_master.sv
// Directed bench for wb_block_master: zero-wait slave model with injectable
// retry/error, write source and read sink, expected values written by hand.
module tb_wb_block_master;

    localparam int Dw   = 32;
    localparam int Aw   = 10;
    localparam int LENw = 8;

`ifdef WB_BLOCK_MASTER_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif
    localparam int SPACING = BURST ? 1 : 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            cmd_valid, cmd_ready, cmd_we;
    logic [Aw-1:0]   cmd_addr;
    logic [LENw-1:0] cmd_len;
    logic [Dw-1:0]   wr_data;
    logic            wr_valid, wr_ready;
    logic [Dw-1:0]   rd_data;
    logic            rd_valid, rd_ready;
    logic            busy, done, err;

    wb_block_master_if #(.Dw(Dw), .Aw(Aw)) bus ();

    wb_block_master #(.Dw(Dw), .Aw(Aw), .LENw(LENw)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .wb        (bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Counters and logs owned by the monitor.
    int cyc_n = 0, ack_cnt = 0, rty_cnt = 0, err_cnt = 0, rd_cnt = 0;
    int done_cnt = 0, cyc_seen = 0, wr_idx = 0;
    int ack_cyc [64];
    logic [Aw-1:0] ack_addr [64];
    logic [2:0]    ack_cti  [64];
    logic [31:0]   ack_dat  [64];
    logic [31:0]   rd_log   [64];
    int            done_cyc = 0, rty_cyc = 0, err_cyc = 0;
    logic          done_err = 1'b0;
    logic [Aw-1:0] rty_addr = '0;

    // Controls owned by the stimulus block.
    int wr_cnt = 0, ack_base = 0;
    int rty_goal = 0, rty_beat = 0, err_goal = 0, err_beat = 0;
    logic [31:0] wtab [64];

    // Zero-wait slave; rty/err fire once on the chosen beat of a command.
    always_comb begin
        bus.m_err_i = bus.m_stb_o && (err_cnt < err_goal) && (ack_cnt - ack_base == err_beat - 1);
        bus.m_rty_i = bus.m_stb_o && !bus.m_err_i && (rty_cnt < rty_goal)
                      && (ack_cnt - ack_base == rty_beat - 1);
        bus.m_ack_i = bus.m_stb_o && !bus.m_err_i && !bus.m_rty_i;
        bus.m_dat_i = 32'hD000_0000 | 32'(bus.m_addr_o);
    end

    always_comb begin
        wr_valid = (wr_idx < wr_cnt);
        wr_data  = wtab[wr_idx % 64];
    end

    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        if (bus.m_cyc_o) cyc_seen <= cyc_seen + 1;
        if (bus.m_stb_o && bus.m_ack_i) begin
            ack_addr[ack_cnt % 64] <= bus.m_addr_o;
            ack_cti[ack_cnt % 64]  <= bus.m_cti_o;
            ack_dat[ack_cnt % 64]  <= bus.m_dat_o;
            ack_cyc[ack_cnt % 64]  <= cyc_n;
            ack_cnt <= ack_cnt + 1;
        end
        if (bus.m_stb_o && bus.m_rty_i) begin
            rty_cnt  <= rty_cnt + 1;
            rty_cyc  <= cyc_n;
            rty_addr <= bus.m_addr_o;
        end
        if (bus.m_stb_o && bus.m_err_i) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc_n;
        end
        if (wr_valid && wr_ready) wr_idx <= wr_idx + 1;
        if (rd_valid && rd_ready) begin
            rd_log[rd_cnt % 64] <= rd_data;
            rd_cnt <= rd_cnt + 1;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc_n;
            done_err <= err;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic we, input logic [Aw-1:0] a,
                            input logic [LENw-1:0] l, output int acc);
        int n = 0;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_seen", 32'(cmd_ready), 32'd1);
        acc = cyc_n;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int base);
        int n = 0;
        while (done_cnt == base && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(done_cnt > base), 32'd1);
    endtask

    initial begin
        int acc, base, d0, wb0, rb0, rt0, er0, cs0, n;
        logic [Aw-1:0] t1_addr [4];
        t1_addr = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};

        reset = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
        rd_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready),    32'd0);
        check("rst_stb",       32'(bus.m_stb_o),  32'd0);
        check("rst_cyc",       32'(bus.m_cyc_o),  32'd0);
        check("rst_we",        32'(bus.m_we_o),   32'd0);
        check("rst_addr",      32'(bus.m_addr_o), 32'd0);
        check("rst_dat",       bus.m_dat_o,       32'd0);
        check("rst_cti",       32'(bus.m_cti_o),  32'd0);
        check("rst_rd_valid",  32'(rd_valid),     32'd0);
        check("rst_wr_ready",  32'(wr_ready),     32'd0);
        check("rst_busy",      32'(busy),         32'd0);
        check("rst_done",      32'(done),         32'd0);
        check("rst_err",       32'(err),          32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // Block write across the address wrap point.
        for (int i = 0; i < 4; i++) wtab[(wr_idx + i) % 64] = 32'hA0 + 32'(i);
        wb0 = wr_idx; wr_cnt = wr_idx + 4;
        base = ack_cnt; d0 = done_cnt;
        send_cmd(1'b1, 10'h3FE, 8'd4, acc);
        wait_done(d0);
        check("t1_acks", 32'(ack_cnt - base), 32'd4);
        check("t1_wr_pulses", 32'(wr_idx - wb0), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("t1_addr", 32'(ack_addr[base + i]), 32'(t1_addr[i]));
            check("t1_cti", 32'(ack_cti[base + i]),
                  BURST ? ((i == 3) ? 32'h7 : 32'h2) : 32'h0);
            check("t1_dat", ack_dat[base + i], 32'hA0 + 32'(i));
            check("t1_beat_cyc", 32'(ack_cyc[base + i]), 32'(acc + 1 + i * SPACING));
        end
        check("t1_done_cyc", 32'(done_cyc), 32'(acc + 2 + 3 * SPACING));
        check("t1_err", 32'(done_err), 32'd0);
        check("t1_idle_busy", 32'(busy), 32'd0);

        // Block read with the read stream stalled after the first beat.
        base = ack_cnt; d0 = done_cnt; rb0 = rd_cnt;
        send_cmd(1'b0, 10'h010, 8'd3, acc);
        check("t2_first_stb", 32'(bus.m_stb_o), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t2_stb_held_low", 32'(bus.m_stb_o), 32'd0);
            check("t2_rd_valid_hold", 32'(rd_valid), 32'd1);
            check("t2_rd_data_hold", rd_data, 32'hD000_0010);
        end
        rd_ready = 1'b1;
        wait_done(d0);
        repeat (2) @(negedge clk);
        check("t2_acks", 32'(ack_cnt - base), 32'd3);
        check("t2_rd_words", 32'(rd_cnt - rb0), 32'd3);
        check("t2_rd0", rd_log[(rb0 + 0) % 64], 32'hD000_0010);
        check("t2_rd1", rd_log[(rb0 + 1) % 64], 32'hD000_0011);
        check("t2_rd2", rd_log[(rb0 + 2) % 64], 32'hD000_0012);
        check("t2_err", 32'(done_err), 32'd0);

        // Retry on beat 2 of a 3-word read.
        ack_base = ack_cnt; base = ack_cnt; d0 = done_cnt; rb0 = rd_cnt; rt0 = rty_cnt;
        rty_beat = 2; rty_goal = rty_cnt + 1;
        send_cmd(1'b0, 10'h100, 8'd3, acc);
        wait_done(d0);
        repeat (2) @(negedge clk);
        check("t3_rty_count", 32'(rty_cnt - rt0), 32'd1);
        check("t3_rty_addr", 32'(rty_addr), 32'h101);
        check("t3_acks", 32'(ack_cnt - base), 32'd3);
        check("t3_reissue_addr", 32'(ack_addr[base + 1]), 32'h101);
        check("t3_reissue_cyc", 32'(ack_cyc[base + 1]), 32'(rty_cyc + 2));
        check("t3_last_addr", 32'(ack_addr[base + 2]), 32'h102);
        check("t3_rd_words", 32'(rd_cnt - rb0), 32'd3);
        check("t3_rd1", rd_log[(rb0 + 1) % 64], 32'hD000_0101);
        check("t3_rd2", rd_log[(rb0 + 2) % 64], 32'hD000_0102);

        // Error on beat 2 of an 8-word write.
        for (int i = 0; i < 8; i++) wtab[(wr_idx + i) % 64] = 32'hB0 + 32'(i);
        wb0 = wr_idx; wr_cnt = wr_idx + 8;
        ack_base = ack_cnt; base = ack_cnt; d0 = done_cnt; er0 = err_cnt;
        err_beat = 2; err_goal = err_cnt + 1;
        send_cmd(1'b1, 10'h040, 8'd8, acc);
        wait_done(d0);
        check("t4_err_seen", 32'(err_cnt - er0), 32'd1);
        check("t4_acks", 32'(ack_cnt - base), 32'd1);
        check("t4_wr_pulses", 32'(wr_idx - wb0), 32'd1);
        check("t4_first_dat", ack_dat[base], 32'hB0);
        check("t4_done_err", 32'(done_err), 32'd1);
        check("t4_done_cyc", 32'(done_cyc), 32'(err_cyc + 1));
        repeat (3) @(negedge clk);
        check("t4_err_holds", 32'(err), 32'd1);
        check("t4_cyc_low", 32'(bus.m_cyc_o), 32'd0);
        wr_cnt = wr_idx;

        // Zero-length command: done without any bus cycle.
        cs0 = cyc_seen; base = ack_cnt; d0 = done_cnt;
        send_cmd(1'b0, 10'h055, 8'd0, acc);
        check("t5_done_now", 32'(done), 32'd1);
        check("t5_err_cleared", 32'(err), 32'd0);
        check("t5_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("t5_done_pulse", 32'(done), 32'd0);
        check("t5_done_cyc", 32'(done_cyc), 32'(acc + 1));
        check("t5_no_cyc", 32'(cyc_seen - cs0), 32'd0);
        check("t5_no_acks", 32'(ack_cnt - base), 32'd0);

        // Reset during beat 3 of an 8-word write.
        for (int i = 0; i < 8; i++) wtab[(wr_idx + i) % 64] = 32'hC0 + 32'(i);
        wb0 = wr_idx; wr_cnt = wr_idx + 8; base = ack_cnt;
        send_cmd(1'b1, 10'h200, 8'd8, acc);
        n = 0;
        while (!((ack_cnt - base) == 2 && bus.m_stb_o === 1'b1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t6_beat3_reached", 32'((ack_cnt - base) == 2 && bus.m_stb_o === 1'b1), 32'd1);
        reset = 1'b0;
        #1;
        check("t6_cyc_async", 32'(bus.m_cyc_o), 32'd0);
        check("t6_stb_async", 32'(bus.m_stb_o), 32'd0);
        check("t6_busy_async", 32'(busy), 32'd0);
        check("t6_cmd_ready_rst", 32'(cmd_ready), 32'd0);
        check("t6_wr_pulses", 32'(wr_idx - wb0), 32'd2);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wr_cnt = wr_idx;
        repeat (2) @(negedge clk);
        check("t6_cmd_ready_after", 32'(cmd_ready), 32'd1);
        check("t6_busy_after", 32'(busy), 32'd0);
        rd_ready = 1'b1;
        base = ack_cnt; d0 = done_cnt; rb0 = rd_cnt;
        send_cmd(1'b0, 10'h2A0, 8'd1, acc);
        wait_done(d0);
        repeat (2) @(negedge clk);
        check("t6_acks", 32'(ack_cnt - base), 32'd1);
        check("t6_addr", 32'(ack_addr[base]), 32'h2A0);
        check("t6_cti", 32'(ack_cti[base]), BURST ? 32'h7 : 32'h0);
        check("t6_rd_words", 32'(rd_cnt - rb0), 32'd1);
        check("t6_rd0", rd_log[rb0 % 64], 32'hD000_02A0);
        check("t6_err", 32'(done_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
